// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master controller.
package spi_pkg;

    localparam int SPI_DATA_W = 8;
    localparam int FRAME_BITS = SPI_DATA_W + 2;

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } spi_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAKE,
        ST_SEL,
        ST_SHIFT,
        ST_TURN,
        ST_RECV,
        ST_GAP
    } master_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_cmd_fifo.sv
// Synchronous {op,data} command FIFO; full/empty derived from pointers carrying a wrap bit.
module spi_cmd_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: frames host commands onto SS_n/MOSI and captures read bytes from MISO.
// Optional command FIFO enabled by defining SPI_MASTER_CMD_FIFO_EN.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W         = SPI_DATA_W,
    parameter int IDLE_GAP       = 2,
    parameter int TURNAROUND     = 1,
    parameter int CMD_FIFO_DEPTH = 4
) (
    input  logic              SCK,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
);
    localparam int FRAME_W = DATA_W + 2;
    // The IDLE cycle before the next accept is the last cycle of the inter-frame gap.
    localparam int GAP_CYC = IDLE_GAP - 1;
    localparam int CNT_W   = $clog2(max_int(max_int(FRAME_W, DATA_W),
                                            max_int(TURNAROUND, GAP_CYC)) + 1);

    localparam logic [CNT_W-1:0] LD_SHIFT = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] LD_RECV  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LD_TURN  = (TURNAROUND > 0) ? CNT_W'(TURNAROUND - 1) : '0;
    localparam logic [CNT_W-1:0] LD_GAP   = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;

    master_state_t      state;
    master_state_t      next_state;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_tc;
    logic [FRAME_W-1:0] frame_q;
    logic [FRAME_W-1:0] go_frame;
    logic [DATA_W-2:0]  rx_q;
    logic               rd_op;
    logic               cmd_go;
    logic               ss_n_d;
    logic               mosi_d;
    logic               rsp_done;

`ifdef SPI_MASTER_CMD_FIFO_EN
    logic fifo_full;
    logic fifo_empty;

    spi_cmd_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (CMD_FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (SCK),
        .rst_n     (rst_n),
        .push      (cmd_valid && !fifo_full),
        .push_data ({cmd_op, cmd_data}),
        .pop       (cmd_go),
        .pop_data  (go_frame),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign cmd_ready = !fifo_full;
    assign cmd_go    = (state == ST_IDLE) && !fifo_empty;
    assign busy      = (state != ST_IDLE) || !fifo_empty;
`else
    assign cmd_ready = (state == ST_IDLE);
    assign cmd_go    = cmd_valid && cmd_ready;
    assign go_frame  = {cmd_op, cmd_data};
    assign busy      = (state != ST_IDLE);
`endif

    assign cnt_tc = (cnt == '0);

    always_ff @(posedge SCK or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (cmd_go) next_state = ST_WAKE;
            ST_WAKE:  next_state = ST_SEL;
            ST_SEL:   next_state = ST_SHIFT;
            ST_SHIFT: if (cnt_tc) begin
                          if (rd_op) next_state = (TURNAROUND > 0) ? ST_TURN : ST_RECV;
                          else       next_state = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
                      end
            ST_TURN:  if (cnt_tc) next_state = ST_RECV;
            ST_RECV:  if (cnt_tc) next_state = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
            ST_GAP:   if (cnt_tc) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // SS_n/MOSI are registered, so they are computed for the state being entered.
    always_comb begin
        ss_n_d   = 1'b1;
        mosi_d   = 1'b0;
        rsp_done = (state == ST_RECV) && cnt_tc;
        case (next_state)
            ST_WAKE, ST_TURN, ST_RECV: ss_n_d = 1'b0;
            ST_SEL, ST_SHIFT: begin
                ss_n_d = 1'b0;
                mosi_d = (state == ST_SHIFT) ? frame_q[FRAME_W-2] : frame_q[FRAME_W-1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge SCK or negedge rst_n) begin
        if (!rst_n) begin
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rx_q      <= '0;
            frame_q   <= '0;
            rd_op     <= 1'b0;
            cnt       <= '0;
        end else begin
            SS_n      <= ss_n_d;
            MOSI      <= mosi_d;
            rsp_valid <= rsp_done;

            if (cmd_go) begin
                frame_q <= go_frame;
                rd_op   <= (spi_op_t'(go_frame[FRAME_W-1 -: 2]) == OP_RD_DATA);
            end else if (state == ST_SHIFT) begin
                frame_q <= {frame_q[FRAME_W-2:0], 1'b0};
            end

            if (state == ST_RECV) rx_q <= {rx_q[DATA_W-3:0], MISO};
            if (rsp_done)         rsp_data <= {rx_q, MISO};

            if (next_state != state) begin
                case (next_state)
                    ST_SHIFT: cnt <= LD_SHIFT;
                    ST_TURN:  cnt <= LD_TURN;
                    ST_RECV:  cnt <= LD_RECV;
                    ST_GAP:   cnt <= LD_GAP;
                    default:  cnt <= '0;
                endcase
            end else if (!cnt_tc) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule
